// File: rtl/exec_sequencer_if.sv
// Handshake and datapath bundle between decode, the exec_sequencer and the shared CLA.
// The slave side is the sequencer; the master side is decode plus the ALU/CLA environment.
`timescale 1ns/1ps
interface exec_sequencer_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             flush;
  logic             is_branch;
  logic             is_jmp;
  logic             is_jr;
  logic [WIDTH-1:0] next_pc;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] imm8_sx;
  logic [WIDTH-1:0] imm11_sx;
  logic [WIDTH-1:0] alu_res;
  logic             br_taken;
  logic [WIDTH-1:0] add_a;
  logic [WIDTH-1:0] add_b;
  logic [WIDTH-1:0] add_sum;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] res_q;
  logic [WIDTH-1:0] pc_q;
  logic [1:0]       state_o;

  modport slave (
    input  start, flush, is_branch, is_jmp, is_jr,
    input  next_pc, rs_val, imm8_sx, imm11_sx, alu_res, br_taken, add_sum,
    output add_a, add_b, busy, done, res_q, pc_q, state_o
  );

  modport master (
    output start, flush, is_branch, is_jmp, is_jr,
    output next_pc, rs_val, imm8_sx, imm11_sx, alu_res, br_taken, add_sum,
    input  add_a, add_b, busy, done, res_q, pc_q, state_o
  );
endinterface

// File: rtl/exec_sequencer.sv
// Execute-stage sequencer: captures the ALU result, then borrows the shared CLA to form the
// next PC (PC-relative branch/jump or register-relative JR) instead of a dedicated PC adder.
`timescale 1ns/1ps
module exec_sequencer #(
  parameter int WIDTH    = 16,
  parameter bit SKIP_TGT = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  exec_sequencer_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ALU  = 2'd1,
    ST_TGT  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  state_t           state_q,  state_d;
  logic             br_q,     br_d;
  logic             jmp_q,    jmp_d;
  logic             jr_q,     jr_d;
  logic             taken_q,  taken_d;
  logic [WIDTH-1:0] npc_q,    npc_d;
  logic [WIDTH-1:0] rs_q,     rs_d;
  logic [WIDTH-1:0] imm8_q,   imm8_d;
  logic [WIDTH-1:0] imm11_q,  imm11_d;
  logic [WIDTH-1:0] res_q,    res_d;
  logic [WIDTH-1:0] pc_q,     pc_d;
  logic [WIDTH-1:0] add_a_q,  add_a_d;
  logic [WIDTH-1:0] add_b_q,  add_b_d;
  logic             busy_q,   busy_d;
  logic             done_q,   done_d;

  logic             any_ctl_s;
  assign any_ctl_s = br_q | jmp_q | jr_q;

  // Next-state, capture and CLA operand selection; flush outranks start and normal advance
  always_comb begin
    state_d = state_q;
    br_d    = br_q;
    jmp_d   = jmp_q;
    jr_d    = jr_q;
    taken_d = taken_q;
    npc_d   = npc_q;
    rs_d    = rs_q;
    imm8_d  = imm8_q;
    imm11_d = imm11_q;
    res_d   = res_q;
    pc_d    = pc_q;
    add_a_d = '0;
    add_b_d = '0;

    if (bus.flush) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            br_d    = bus.is_branch;
            jmp_d   = bus.is_jmp;
            jr_d    = bus.is_jr;
            npc_d   = bus.next_pc;
            rs_d    = bus.rs_val;
            imm8_d  = bus.imm8_sx;
            imm11_d = bus.imm11_sx;
            state_d = ST_ALU;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_ALU: begin
          res_d   = bus.alu_res;
          taken_d = bus.br_taken & br_q;
          if (SKIP_TGT && !any_ctl_s) begin
            pc_d    = npc_q;
            state_d = ST_DONE;
          end else begin
            // Operands are registered on entry to TGT so the CLA sees them for the whole cycle
            add_a_d = jr_q ? rs_q : npc_q;
            if (jr_q) begin
              add_b_d = imm8_q;
            end else if (jmp_q) begin
              add_b_d = imm11_q;
            end else if (taken_d) begin
              add_b_d = imm8_q;
            end else begin
              add_b_d = '0;
            end
            state_d = ST_TGT;
          end
        end
        ST_TGT: begin
          pc_d    = bus.add_sum;
          state_d = ST_DONE;
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      br_q    <= 1'b0;
      jmp_q   <= 1'b0;
      jr_q    <= 1'b0;
      taken_q <= 1'b0;
      npc_q   <= '0;
      rs_q    <= '0;
      imm8_q  <= '0;
      imm11_q <= '0;
      res_q   <= '0;
      pc_q    <= '0;
      add_a_q <= '0;
      add_b_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      br_q    <= br_d;
      jmp_q   <= jmp_d;
      jr_q    <= jr_d;
      taken_q <= taken_d;
      npc_q   <= npc_d;
      rs_q    <= rs_d;
      imm8_q  <= imm8_d;
      imm11_q <= imm11_d;
      res_q   <= res_d;
      pc_q    <= pc_d;
      add_a_q <= add_a_d;
      add_b_q <= add_b_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.add_a   = add_a_q;
  assign bus.add_b   = add_b_q;
  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.res_q   = res_q;
  assign bus.pc_q    = pc_q;
  assign bus.state_o = state_q;

endmodule

// File: tb/tb_exec_sequencer.sv
// Self-checking bench for exec_sequencer: latency-based transaction model checked every cycle,
// plus directed operations with hand-computed results.
`timescale 1ns/1ps
module tb_exec_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   pass_cnt  = 0;
  int   total_cnt = 0;
  logic chk_en    = 1'b0;

  exec_sequencer_if #(.WIDTH(16)) bus ();

  exec_sequencer #(.WIDTH(16), .SKIP_TGT(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Shared CLA: carry-in 0, carry-out dropped by the 16-bit result
  assign bus.add_sum = bus.add_a + bus.add_b;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Transaction model: an accepted op lives for 2 cycles (no control class) or 3 cycles
  logic        m_active = 1'b0;
  int          m_age    = 0;
  logic        m_tgt    = 1'b0;
  logic        m_br = 1'b0, m_jmp = 1'b0, m_jr = 1'b0;
  logic [15:0] m_npc = 16'h0, m_rs = 16'h0, m_i8 = 16'h0, m_i11 = 16'h0;
  logic [15:0] m_add_a = 16'h0, m_add_b = 16'h0;
  logic [15:0] cur_res = 16'h0, cur_pc = 16'h0;

  function automatic logic [15:0] f_base(input logic jr, input logic [15:0] rs, input logic [15:0] npc);
    return jr ? rs : npc;
  endfunction

  function automatic logic [15:0] f_disp(input logic br, input logic jmp, input logic jr, input logic tk,
                                         input logic [15:0] i8, input logic [15:0] i11);
    if (jr) return i8;
    if (jmp) return i11;
    if (br && tk) return i8;
    return 16'h0000;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      m_active <= 1'b0;
      cur_res  <= 16'h0;
      cur_pc   <= 16'h0;
      m_add_a  <= 16'h0;
      m_add_b  <= 16'h0;
    end else if (m_active) begin
      if (bus.flush) begin
        m_active <= 1'b0;
      end else begin
        m_age <= m_age + 1;
        if (m_age == 0) begin
          cur_res <= bus.alu_res;
          if (!m_tgt) cur_pc <= m_npc;
          m_add_a <= f_base(m_jr, m_rs, m_npc);
          m_add_b <= f_disp(m_br, m_jmp, m_jr, bus.br_taken, m_i8, m_i11);
        end
        if (m_age == 1 && m_tgt) cur_pc <= 16'(m_add_a + m_add_b);
        if (m_age == (m_tgt ? 2 : 1)) m_active <= 1'b0;
      end
    end else if (bus.start && !bus.flush) begin
      m_active <= 1'b1;
      m_age    <= 0;
      m_br     <= bus.is_branch;
      m_jmp    <= bus.is_jmp;
      m_jr     <= bus.is_jr;
      m_tgt    <= bus.is_branch | bus.is_jmp | bus.is_jr;
      m_npc    <= bus.next_pc;
      m_rs     <= bus.rs_val;
      m_i8     <= bus.imm8_sx;
      m_i11    <= bus.imm11_sx;
    end
  end

  // Every-cycle comparison of all outputs against the model
  always @(negedge clk) begin
    if (chk_en) begin
      logic [1:0]  e_state;
      logic        e_tgt_cyc;
      e_tgt_cyc = m_active && m_tgt && (m_age == 1);
      if (!m_active)                  e_state = 2'd0;
      else if (m_age == 0)            e_state = 2'd1;
      else if (e_tgt_cyc)             e_state = 2'd2;
      else                            e_state = 2'd3;
      chk("busy",  {15'd0, bus.busy}, {15'd0, m_active});
      chk("done",  {15'd0, bus.done}, {15'd0, (m_active && m_age == (m_tgt ? 2 : 1))});
      chk("state", {14'd0, bus.state_o}, {14'd0, e_state});
      chk("add_a", bus.add_a, e_tgt_cyc ? m_add_a : 16'h0000);
      chk("add_b", bus.add_b, e_tgt_cyc ? m_add_b : 16'h0000);
      chk("res_q", bus.res_q, cur_res);
      chk("pc_q",  bus.pc_q,  cur_pc);
    end
  end

  task automatic set_ops(input logic br, input logic jmp, input logic jr,
                         input logic [15:0] npc, input logic [15:0] rs, input logic [15:0] i8,
                         input logic [15:0] i11, input logic [15:0] alu, input logic tk);
    bus.is_branch = br;
    bus.is_jmp    = jmp;
    bus.is_jr     = jr;
    bus.next_pc   = npc;
    bus.rs_val    = rs;
    bus.imm8_sx   = i8;
    bus.imm11_sx  = i11;
    bus.alu_res   = alu;
    bus.br_taken  = tk;
  endtask

  task automatic run_op(input string nm, input logic br, input logic jmp, input logic jr,
                        input logic [15:0] npc, input logic [15:0] rs, input logic [15:0] i8,
                        input logic [15:0] i11, input logic [15:0] alu, input logic tk,
                        input logic [15:0] e_res, input logic [15:0] e_pc, input int e_lat,
                        input logic [15:0] e_a, input logic [15:0] e_b);
    int          n;
    logic        got;
    logic [15:0] sa, sb;
    @(posedge clk); #1;
    set_ops(br, jmp, jr, npc, rs, i8, i11, alu, tk);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n = 0; got = 1'b0; sa = 16'h0; sb = 16'h0;
    while (!got && n < 8) begin
      @(negedge clk);
      n++;
      if (n == 2) begin
        sa = bus.add_a;
        sb = bus.add_b;
      end
      if (bus.done) got = 1'b1;
    end
    chk({nm, " latency"}, 16'(n), 16'(e_lat));
    chk({nm, " res"}, bus.res_q, e_res);
    chk({nm, " pc"},  bus.pc_q,  e_pc);
    if (e_lat == 3) begin
      chk({nm, " add_a"}, sa, e_a);
      chk({nm, " add_b"}, sb, e_b);
    end
  endtask

  initial begin
    int cnt;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    set_ops(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0, 16'h0, 16'h0, 1'b0);
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("reset res_q", bus.res_q, 16'h0000);
    chk("reset pc_q",  bus.pc_q,  16'h0000);
    chk("reset busy",  {15'd0, bus.busy}, 16'h0000);
    chk("reset add_a", bus.add_a, 16'h0000);

    //     name         br    jmp   jr    npc       rs        i8        i11       alu       tk    res       pc        lat add_a     add_b
    run_op("add",       1'b0, 1'b0, 1'b0, 16'h0102, 16'h0000, 16'h0000, 16'h0000, 16'h1234, 1'b0, 16'h1234, 16'h0102, 2, 16'h0000, 16'h0000);
    run_op("br_taken",  1'b1, 1'b0, 1'b0, 16'h0100, 16'h0000, 16'hFFF0, 16'h0000, 16'h0001, 1'b1, 16'h0001, 16'h00F0, 3, 16'h0100, 16'hFFF0);
    run_op("br_ntaken", 1'b1, 1'b0, 1'b0, 16'h0100, 16'h0000, 16'hFFF0, 16'h0000, 16'h0000, 1'b0, 16'h0000, 16'h0100, 3, 16'h0100, 16'h0000);
    run_op("jr_wrap",   1'b0, 1'b0, 1'b1, 16'h0300, 16'hFFFE, 16'h0004, 16'h0000, 16'hABCD, 1'b0, 16'hABCD, 16'h0002, 3, 16'hFFFE, 16'h0004);
    run_op("jmp",       1'b0, 1'b1, 1'b0, 16'h0200, 16'h0000, 16'h0000, 16'h0400, 16'h0042, 1'b0, 16'h0042, 16'h0600, 3, 16'h0200, 16'h0400);
    run_op("prec_jr",   1'b1, 1'b1, 1'b1, 16'h0500, 16'h1000, 16'h0010, 16'h0300, 16'h7777, 1'b1, 16'h7777, 16'h1010, 3, 16'h1000, 16'h0010);
    run_op("prec_jmp",  1'b1, 1'b1, 1'b0, 16'h0500, 16'h1000, 16'h0010, 16'h0300, 16'h8888, 1'b1, 16'h8888, 16'h0800, 3, 16'h0500, 16'h0300);

    // start held high: one done every 4 cycles
    @(posedge clk); #1;
    set_ops(1'b1, 1'b0, 1'b0, 16'h0400, 16'h0000, 16'h0020, 16'h0000, 16'h0101, 1'b1);
    bus.start = 1'b1;
    cnt = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (bus.done) cnt++;
    end
    #1;
    bus.start = 1'b0;
    chk("held_start done count", 16'(cnt), 16'd4);
    chk("held_start pc", bus.pc_q, 16'h0420);

    // flush during TGT: idle next cycle, no done
    @(posedge clk); #1;
    set_ops(1'b1, 1'b0, 1'b0, 16'h0600, 16'h0000, 16'h0008, 16'h0000, 16'h0202, 1'b1);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    chk("flush pre state", {14'd0, bus.state_o}, 16'd2);
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    chk("flush state", {14'd0, bus.state_o}, 16'd0);
    chk("flush busy",  {15'd0, bus.busy}, 16'd0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.done) cnt++;
    end
    chk("flush no done", 16'(cnt), 16'd0);

    // flush in IDLE blocks a same-cycle start
    @(posedge clk); #1;
    bus.start = 1'b1;
    bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    bus.flush = 1'b0;
    chk("idle_flush busy", {15'd0, bus.busy}, 16'd0);

    // reset during ALU clears results, no done
    @(posedge clk); #1;
    set_ops(1'b0, 1'b0, 1'b0, 16'h0700, 16'h0000, 16'h0000, 16'h0000, 16'h5555, 1'b0);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst res_q", bus.res_q, 16'h0000);
    chk("rst pc_q",  bus.pc_q,  16'h0000);
    chk("rst busy",  {15'd0, bus.busy}, 16'd0);
    cnt = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (bus.done) cnt++;
    end
    chk("rst no done", 16'(cnt), 16'd0);

    @(posedge clk); #1;
    chk_en = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
